// File: rtl/mnist_class_scorer.sv
// Three-stage result scorer for the MNIST LUT network: per-class popcount, argmax, label compare and accuracy counters.
// Optional winning-score output enabled by defining MNIST_CLASS_SCORER_SCORE_OUT_EN.
module mnist_class_scorer #(
   parameter  int USER_WIDTH  = 8,
   parameter  int CLASS_NUM   = 10,
   parameter  int CHANNEL_NUM = 1,
   parameter  int CLASS_WIDTH = 4,
   parameter  int COUNT_WIDTH = 32,
   localparam int SCORE_RAW   = $clog2(CHANNEL_NUM + 1),
   localparam int SCORE_WIDTH = (SCORE_RAW < 1) ? 1 : SCORE_RAW
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             cke,
   input  logic                             clear,
   input  logic                             in_last,
   input  logic [USER_WIDTH-1:0]            in_user,
   input  logic [CLASS_NUM*CHANNEL_NUM-1:0] in_data,
   input  logic                             in_valid,
   output logic                             out_last,
   output logic [USER_WIDTH-1:0]            out_label,
   output logic [CLASS_WIDTH-1:0]           out_class,
   output logic                             out_match,
   output logic                             out_valid,
`ifdef MNIST_CLASS_SCORER_SCORE_OUT_EN
   output logic [SCORE_WIDTH-1:0]           out_score,
`endif
   output logic [COUNT_WIDTH-1:0]           total_count,
   output logic [COUNT_WIDTH-1:0]           ok_count,
   output logic                             done
);

   localparam int CMP_WIDTH = (USER_WIDTH > CLASS_WIDTH) ? USER_WIDTH : CLASS_WIDTH;

   // ---------------- stage 1: popcount ----------------
   logic [SCORE_WIDTH-1:0] score_d [CLASS_NUM];
   logic [SCORE_WIDTH-1:0] score_q [CLASS_NUM];
   logic                   valid1;
   logic                   last1;
   logic [USER_WIDTH-1:0]  label1;

   // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      for (int i = 0; i < CLASS_NUM; i++) begin
         score_d[i] = '0;
         for (int j = 0; j < CHANNEL_NUM; j++)
            score_d[i] = score_d[i] + SCORE_WIDTH'(in_data[j*CLASS_NUM+i]);
      end
   end

   // NOTE: registers use non-blocking assignments so all stages sample the same pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid1 <= 1'b0;
         last1  <= 1'b0;
         label1 <= '0;
         for (int i = 0; i < CLASS_NUM; i++) score_q[i] <= '0;
      end else if (cke) begin
         valid1 <= in_valid;
         if (in_valid) begin
            last1  <= in_last;
            label1 <= in_user;
            for (int i = 0; i < CLASS_NUM; i++) score_q[i] <= score_d[i];
         end
      end
   end

   // ---------------- stage 2: argmax ----------------
   logic [SCORE_WIDTH-1:0] best_score;
   logic [CLASS_WIDTH-1:0] best_class;
   logic                   valid2;
   logic                   last2;
   logic [USER_WIDTH-1:0]  label2;
   logic [CLASS_WIDTH-1:0] class2;

   // Starting from score 0 with strict-greater means ties keep the lowest index and all-zero leaves "no prediction".
   always_comb begin
      best_score = '0;
      best_class = '1;
      for (int i = 0; i < CLASS_NUM; i++) begin
         if (score_q[i] > best_score) begin
            best_score = score_q[i];
            best_class = CLASS_WIDTH'(i);
         end
      end
   end

`ifdef MNIST_CLASS_SCORER_SCORE_OUT_EN
   logic [SCORE_WIDTH-1:0] score2;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid2 <= 1'b0;
         last2  <= 1'b0;
         label2 <= '0;
         class2 <= '1;
`ifdef MNIST_CLASS_SCORER_SCORE_OUT_EN
         score2 <= '0;
`endif
      end else if (cke) begin
         valid2 <= valid1;
         if (valid1) begin
            last2  <= last1;
            label2 <= label1;
            class2 <= best_class;
`ifdef MNIST_CLASS_SCORER_SCORE_OUT_EN
            score2 <= best_score;
`endif
         end
      end
   end

   // ---------------- stage 3: compare and count ----------------
   logic [CMP_WIDTH-1:0] label_ext;
   logic [CMP_WIDTH-1:0] class_ext;
   logic                 has_pred;
   logic                 match_d;

   always_comb begin
      label_ext = CMP_WIDTH'(label2);
      class_ext = CMP_WIDTH'(class2);
      has_pred  = (class2 != '1);
      match_d   = has_pred && (label_ext == class_ext) && (label_ext < CMP_WIDTH'(CLASS_NUM));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_label <= '0;
         out_class <= '1;
         out_match <= 1'b0;
`ifdef MNIST_CLASS_SCORER_SCORE_OUT_EN
         out_score <= '0;
`endif
      end else if (cke) begin
         out_valid <= valid2;
         if (valid2) begin
            out_last  <= last2;
            out_label <= label2;
            out_class <= class2;
            out_match <= match_d;
`ifdef MNIST_CLASS_SCORER_SCORE_OUT_EN
            out_score <= score2;
`endif
         end
      end
   end

   // Clear beats counting; done freezes the counters until the next clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         total_count <= '0;
         ok_count    <= '0;
         done        <= 1'b0;
      end else if (cke) begin
         if (clear) begin
            total_count <= '0;
            ok_count    <= '0;
            done        <= 1'b0;
         end else if (valid2 && !done) begin
            if (total_count != '1) total_count <= total_count + COUNT_WIDTH'(1);
            if (match_d && ok_count != '1) ok_count <= ok_count + COUNT_WIDTH'(1);
            if (last2) done <= 1'b1;
         end
      end
   end

endmodule
